// File: rtl/cmac_csb_reg_initiator.sv
// CSB request initiator for the CMAC register slice: decodes one CSB request at a time
// into a single-cycle register access and returns the CSB response when one is due.
module cmac_csb_reg_initiator #(
  parameter logic [11:0] BLK_BASE = 12'h007,
  parameter int unsigned RD_WAIT  = 0
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        csb_req_pvld,
  output logic        csb_req_prdy,
  input  logic [62:0] csb_req_pd,
  output logic        csb_resp_valid,
  output logic [33:0] csb_resp_pd,
  output logic [11:0] reg_offset,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data
);

  typedef enum logic [1:0] {StIdle, StAcc, StWait, StResp} state_e;

  localparam logic [1:0] WaitLoad = (RD_WAIT > 0) ? 2'(RD_WAIT - 1) : 2'd0;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        nposted_q, nposted_d;
  logic        hit_q, hit_d;
  logic        legal_q, legal_d;
  logic [11:0] offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_en_q, wr_en_d;
  logic        resp_valid_q, resp_valid_d;
  logic [33:0] resp_pd_q, resp_pd_d;

  logic        req_hit;
  logic        req_legal;
  logic [33:0] rd_resp;
  logic        unused_pd;

  // srcpriv and level carry no meaning for this slice.
  assign unused_pd = ^{csb_req_pd[62:61], csb_req_pd[56]};

  assign req_hit   = (csb_req_pd[21:10] == BLK_BASE);
  assign req_legal = req_hit && (csb_req_pd[60:57] == 4'hF);
  assign rd_resp   = {1'b0, !hit_q, hit_q ? reg_rd_data : 32'h0};

  assign csb_req_prdy   = (state_q == StIdle);
  assign csb_resp_valid = resp_valid_q;
  assign csb_resp_pd    = resp_pd_q;
  assign reg_offset     = offset_q;
  assign reg_wr_data    = wdata_q;
  assign reg_wr_en      = wr_en_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    nposted_d    = nposted_q;
    hit_d        = hit_q;
    legal_d      = legal_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    wr_en_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_pd_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (csb_req_pvld) begin
          write_d   = csb_req_pd[54];
          nposted_d = csb_req_pd[55];
          hit_d     = req_hit;
          legal_d   = req_legal;
          offset_d  = {csb_req_pd[9:0], 2'b00};
          wdata_d   = csb_req_pd[53:22];
          wr_en_d   = csb_req_pd[54] && req_legal;
          cnt_d     = WaitLoad;
          state_d   = StAcc;
        end
      end
      StAcc: begin
        if (write_q) begin
          if (nposted_q) begin
            resp_valid_d = 1'b1;
            resp_pd_d    = {1'b1, !legal_q, 32'h0};
            state_d      = StResp;
          end else begin
            state_d = StIdle;
          end
        end else if (RD_WAIT != 0) begin
          state_d = StWait;
        end else begin
          // Read data is sampled on the edge that leaves the last access cycle.
          resp_valid_d = 1'b1;
          resp_pd_d    = rd_resp;
          state_d      = StResp;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          resp_valid_d = 1'b1;
          resp_pd_d    = rd_resp;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      write_q      <= 1'b0;
      nposted_q    <= 1'b0;
      hit_q        <= 1'b0;
      legal_q      <= 1'b0;
      offset_q     <= 12'h0;
      wdata_q      <= 32'h0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= 34'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      nposted_q    <= nposted_d;
      hit_q        <= hit_d;
      legal_q      <= legal_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      wr_en_q      <= wr_en_d;
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
    end
  end

endmodule

// File: tb/tb_cmac_csb_reg_initiator.sv
// Directed bench for cmac_csb_reg_initiator: three instances with RD_WAIT of 0, 3 and 2
// share clock, reset and request data, each with its own pvld and register-file model.
module tb_cmac_csb_reg_initiator;

  logic        clk;
  logic        rstn;
  logic        pvld0, pvld3, pvld2;
  logic [62:0] pd;

  logic        prdy0, rv0, we0;
  logic [33:0] rpd0;
  logic [11:0] off0;
  logic [31:0] wd0, rd0;
  logic        prdy3, rv3, we3;
  logic [33:0] rpd3;
  logic [11:0] off3;
  logic [31:0] wd3, rd3;
  logic        prdy2, rv2, we2;
  logic [33:0] rpd2;
  logic [11:0] off2;
  logic [31:0] wd2, rd2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] wr_off[8];
  logic [31:0] wr_dat[8];
  logic [33:0] resp_q[8];

  function automatic logic [62:0] pack(input logic [21:0] a, input logic [31:0] d,
                                       input logic w, input logic np, input logic [3:0] be);
    pack = {2'b00, be, 1'b0, np, w, d, a};
  endfunction

  // Register file model: one known register, the rest echo their offset.
  function automatic logic [31:0] mem(input logic [11:0] off);
    mem = (off == 12'h00C) ? 32'h00002001 : {20'hABC00, off};
  endfunction

  assign rd0 = mem(off0);
  assign rd3 = mem(off3);
  assign rd2 = mem(off2);

  cmac_csb_reg_initiator #(.BLK_BASE(12'h007), .RD_WAIT(0)) u0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .csb_req_pvld(pvld0), .csb_req_prdy(prdy0),
    .csb_req_pd(pd), .csb_resp_valid(rv0), .csb_resp_pd(rpd0), .reg_offset(off0),
    .reg_wr_data(wd0), .reg_wr_en(we0), .reg_rd_data(rd0)
  );
  cmac_csb_reg_initiator #(.BLK_BASE(12'h007), .RD_WAIT(3)) u3 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .csb_req_pvld(pvld3), .csb_req_prdy(prdy3),
    .csb_req_pd(pd), .csb_resp_valid(rv3), .csb_resp_pd(rpd3), .reg_offset(off3),
    .reg_wr_data(wd3), .reg_wr_en(we3), .reg_rd_data(rd3)
  );
  cmac_csb_reg_initiator #(.BLK_BASE(12'h007), .RD_WAIT(2)) u2 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .csb_req_pvld(pvld2), .csb_req_prdy(prdy2),
    .csb_req_pd(pd), .csb_resp_valid(rv2), .csb_resp_pd(rpd2), .reg_offset(off2),
    .reg_wr_data(wd2), .reg_wr_en(we2), .reg_rd_data(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    pvld0 = 1'b0; pvld3 = 1'b0; pvld2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; pvld0 = 1'b0; pvld3 = 1'b0; pvld2 = 1'b0; pd = '0;
    #12;
    n_checks++; if (prdy0 !== 1'b1) begin n_fail++; $display("FAIL rst_prdy: got %b want 1", prdy0); end
    n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rv0); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (prdy0 !== 1'b1) begin n_fail++; $display("FAIL rel_prdy: got %b want 1", prdy0); end
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL rel_wr_en: got %b want 0", we0); end
    n_checks++; if (off0 !== 12'h0) begin n_fail++; $display("FAIL rel_offset: got %h want 000", off0); end
    n_checks++; if (wd0 !== 32'h0) begin n_fail++; $display("FAIL rel_wdata: got %h want 0", wd0); end
    n_checks++; if (rpd0 !== 34'h0) begin n_fail++; $display("FAIL rel_resp_pd: got %h want 0", rpd0); end
  endtask

  task automatic test_posted_write;
    n_checks++; if (prdy0 !== 1'b1) begin n_fail++; $display("FAIL pw_prdy0: got %b want 1", prdy0); end
    pd = pack(22'h1C03, 32'h00002001, 1'b1, 1'b0, 4'hF); pvld0 = 1'b1;
    @(negedge clk); pvld0 = 1'b0;
    n_checks++; if (we0 !== 1'b1) begin n_fail++; $display("FAIL pw_wr_en: got %b want 1", we0); end
    n_checks++; if (off0 !== 12'h00C) begin n_fail++; $display("FAIL pw_offset: got %h want 00c", off0); end
    n_checks++; if (wd0 !== 32'h00002001) begin n_fail++; $display("FAIL pw_wdata: got %h want 00002001", wd0); end
    n_checks++; if (prdy0 !== 1'b0) begin n_fail++; $display("FAIL pw_prdy_acc: got %b want 0", prdy0); end
    @(negedge clk);
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL pw_wr_en_once: got %b want 0", we0); end
    n_checks++; if (prdy0 !== 1'b1) begin n_fail++; $display("FAIL pw_prdy_back: got %b want 1", prdy0); end
    n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL pw_no_resp: got %b want 0", rv0); end
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL pw_no_resp2: got %b want 0", rv0); end
    idle(2);
  endtask

  task automatic test_read;
    pd = pack(22'h1C03, 32'h0, 1'b0, 1'b0, 4'hF); pvld0 = 1'b1;
    @(negedge clk); pvld0 = 1'b0;
    n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL rd_valid_acc: got %b want 0", rv0); end
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL rd_wr_en: got %b want 0", we0); end
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b want 1", rv0); end
    n_checks++; if (rpd0 !== 34'h0_0000_2001) begin n_fail++; $display("FAIL rd_pd: got %h want 000002001", rpd0); end
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL rd_wr_en2: got %b want 0", we0); end
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b want 0", rv0); end
    n_checks++; if (rpd0 !== 34'h0) begin n_fail++; $display("FAIL rd_pd_zero: got %h want 0", rpd0); end
    n_checks++; if (prdy0 !== 1'b1) begin n_fail++; $display("FAIL rd_prdy: got %b want 1", prdy0); end
    idle(2);
  endtask

  task automatic test_read_wait3;
    pd = pack(22'h1C03, 32'h0, 1'b0, 1'b0, 4'hF); pvld3 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); pvld3 = 1'b0;
      if (k <= 4) begin
        n_checks++;
        if (off3 !== 12'h00C) begin n_fail++; $display("FAIL w3_offset k=%0d: got %h want 00c", k, off3); end
      end
      n_checks++;
      if (rv3 !== (k == 5)) begin n_fail++; $display("FAIL w3_valid k=%0d: got %b want %b", k, rv3, k == 5); end
      if (k == 5) begin
        n_checks++;
        if (rpd3 !== 34'h0_0000_2001) begin n_fail++; $display("FAIL w3_pd: got %h want 000002001", rpd3); end
      end
    end
    n_checks++; if (prdy3 !== 1'b1) begin n_fail++; $display("FAIL w3_prdy: got %b want 1", prdy3); end
    idle(2);
  endtask

  task automatic test_np_write;
    // Legal non-posted write, then out-of-range write and read.
    pd = pack(22'h1C05, 32'h12345678, 1'b1, 1'b1, 4'hF); pvld0 = 1'b1;
    @(negedge clk); pvld0 = 1'b0;
    n_checks++; if (we0 !== 1'b1) begin n_fail++; $display("FAIL np_wr_en: got %b want 1", we0); end
    n_checks++; if (off0 !== 12'h014) begin n_fail++; $display("FAIL np_offset: got %h want 014", off0); end
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1 || rpd0 !== 34'h2_0000_0000) begin
      n_fail++; $display("FAIL np_resp: got %b/%h want 1/200000000", rv0, rpd0); end
    @(negedge clk);
    pd = pack(22'h2C02, 32'hDEADBEEF, 1'b1, 1'b1, 4'hF); pvld0 = 1'b1;
    @(negedge clk); pvld0 = 1'b0;
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL oor_wr_en: got %b want 0", we0); end
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1 || rpd0 !== 34'h3_0000_0000) begin
      n_fail++; $display("FAIL oor_wr_resp: got %b/%h want 1/300000000", rv0, rpd0); end
    @(negedge clk);
    pd = pack(22'h0002, 32'h0, 1'b0, 1'b0, 4'hF); pvld0 = 1'b1;
    @(negedge clk); pvld0 = 1'b0;
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1 || rpd0 !== 34'h1_0000_0000) begin
      n_fail++; $display("FAIL oor_rd_resp: got %b/%h want 1/100000000", rv0, rpd0); end
    idle(2);
  endtask

  task automatic test_partial_write;
    pd = pack(22'h1C03, 32'h0000BEEF, 1'b1, 1'b1, 4'h3); pvld0 = 1'b1;
    @(negedge clk); pvld0 = 1'b0;
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL pwr_np_wr_en: got %b want 0", we0); end
    @(negedge clk);
    n_checks++; if (rv0 !== 1'b1 || rpd0 !== 34'h3_0000_0000) begin
      n_fail++; $display("FAIL pwr_np_resp: got %b/%h want 1/300000000", rv0, rpd0); end
    @(negedge clk);
    pd = pack(22'h1C03, 32'h0000BEEF, 1'b1, 1'b0, 4'h3); pvld0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); pvld0 = 1'b0;
      n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL pwr_p_wr_en k=%0d: got %b want 0", k, we0); end
      n_checks++; if (rv0 !== 1'b0) begin n_fail++; $display("FAIL pwr_p_resp k=%0d: got %b want 0", k, rv0); end
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [62:0] reqs[4];
    logic [62:0] junk;
    int idx = 0;
    int nwr = 0;
    int nresp = 0;
    reqs[0] = pack(22'h1C01, 32'h000000A1, 1'b1, 1'b0, 4'hF);
    reqs[1] = pack(22'h1C01, 32'h0, 1'b0, 1'b0, 4'hF);
    reqs[2] = pack(22'h1C02, 32'h000000B2, 1'b1, 1'b1, 4'hF);
    reqs[3] = pack(22'h1C03, 32'h0, 1'b0, 1'b0, 4'hF);
    junk    = pack(22'h1C3F, 32'h00000BAD, 1'b1, 1'b1, 4'hF);
    pd = reqs[0]; pvld0 = 1'b1; idx = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (we0) begin
        if (nwr < 8) begin wr_off[nwr] = off0; wr_dat[nwr] = wd0; end
        nwr++;
      end
      if (rv0) begin
        if (nresp < 8) resp_q[nresp] = rpd0;
        nresp++;
      end
      if (prdy0) begin
        if (idx < 4) begin pd = reqs[idx]; idx++; end
        else pvld0 = 1'b0;
      end else begin
        pd = junk;
      end
    end
    n_checks++; if (idx !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", idx); end
    n_checks++; if (nwr !== 2) begin n_fail++; $display("FAIL b2b_nwr: got %0d want 2", nwr); end
    n_checks++; if (wr_off[0] !== 12'h004 || wr_dat[0] !== 32'hA1) begin
      n_fail++; $display("FAIL b2b_wr0: got %h/%h want 004/000000a1", wr_off[0], wr_dat[0]); end
    n_checks++; if (wr_off[1] !== 12'h008 || wr_dat[1] !== 32'hB2) begin
      n_fail++; $display("FAIL b2b_wr1: got %h/%h want 008/000000b2", wr_off[1], wr_dat[1]); end
    n_checks++; if (nresp !== 3) begin n_fail++; $display("FAIL b2b_nresp: got %0d want 3", nresp); end
    n_checks++; if (resp_q[0] !== 34'h0_ABC0_0004) begin
      n_fail++; $display("FAIL b2b_resp0: got %h want 0abc00004", resp_q[0]); end
    n_checks++; if (resp_q[1] !== 34'h2_0000_0000) begin
      n_fail++; $display("FAIL b2b_resp1: got %h want 200000000", resp_q[1]); end
    n_checks++; if (resp_q[2] !== 34'h0_0000_2001) begin
      n_fail++; $display("FAIL b2b_resp2: got %h want 000002001", resp_q[2]); end
    idle(2);
  endtask

  task automatic test_reset_mid_read;
    pd = pack(22'h1C03, 32'h0, 1'b0, 1'b0, 4'hF); pvld2 = 1'b1;
    @(negedge clk); pvld2 = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++; if (prdy2 !== 1'b1) begin n_fail++; $display("FAIL mr_prdy: got %b want 1", prdy2); end
    n_checks++; if (off2 !== 12'h0) begin n_fail++; $display("FAIL mr_offset: got %h want 000", off2); end
    n_checks++; if (rv2 !== 1'b0 || rpd2 !== 34'h0) begin
      n_fail++; $display("FAIL mr_resp: got %b/%h want 0/0", rv2, rpd2); end
    n_checks++; if (we2 !== 1'b0 || wd2 !== 32'h0) begin
      n_fail++; $display("FAIL mr_wr: got %b/%h want 0/0", we2, wd2); end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (rv2 !== 1'b0 || we2 !== 1'b0) begin
        n_fail++; $display("FAIL mr_post k=%0d: got valid=%b wr_en=%b want 0/0", k, rv2, we2); end
    end
    pd = pack(22'h1C07, 32'h0, 1'b0, 1'b0, 4'hF); pvld2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); pvld2 = 1'b0;
      n_checks++;
      if (rv2 !== (k == 4)) begin n_fail++; $display("FAIL mr_rd_valid k=%0d: got %b want %b", k, rv2, k == 4); end
      if (k == 4) begin
        n_checks++;
        if (rpd2 !== 34'h0_ABC0_001C) begin n_fail++; $display("FAIL mr_rd_pd: got %h want 0abc0001c", rpd2); end
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_posted_write;
    test_read;
    test_read_wait3;
    test_np_write;
    test_partial_write;
    test_back_to_back;
    test_reset_mid_read;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
